// File: rtl/na_gate_update.sv
// Hodgkin-Huxley sodium gate update: advances m and h by one forward-Euler step per clock,
// using piecewise-linear alpha/beta rate tables indexed by membrane potential.
module na_gate_update #(
    parameter logic signed [15:0] M_INIT = 16'sd1734,
    parameter logic signed [15:0] H_INIT = 16'sd19540
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] V,
    input  logic [15:0] dt,
    output logic [15:0] m_next,
    output logic [15:0] h_next
);

    localparam logic signed [15:0] VMin = -16'sd24576;
    localparam logic signed [15:0] VMax = 16'sd16383;

    // Rate tables: unsigned Q8.8 at V = -96 + 8*idx mV, idx = 0..20.
    function automatic logic [15:0] alpha_m_lut(input logic [4:0] idx);
        logic [15:0] t;
        case (idx)
            5'd0:    t = 16'd5;
            5'd1:    t = 16'd10;
            5'd2:    t = 16'd19;
            5'd3:    t = 16'd35;
            5'd4:    t = 16'd61;
            5'd5:    t = 16'd104;
            5'd6:    t = 16'd167;
            5'd7:    t = 16'd256;
            5'd8:    t = 16'd372;
            5'd9:    t = 16'd513;
            5'd10:   t = 16'd676;
            5'd11:   t = 16'd854;
            5'd12:   t = 16'd1043;
            5'd13:   t = 16'd1239;
            5'd14:   t = 16'd1439;
            5'd15:   t = 16'd1641;
            5'd16:   t = 16'd1845;
            5'd17:   t = 16'd2049;
            5'd18:   t = 16'd2253;
            5'd19:   t = 16'd2458;
            default: t = 16'd2662;
        endcase
        return t;
    endfunction

    function automatic logic [15:0] beta_m_lut(input logic [4:0] idx);
        logic [15:0] t;
        case (idx)
            5'd0:    t = 16'd5731;
            5'd1:    t = 16'd3675;
            5'd2:    t = 16'd2356;
            5'd3:    t = 16'd1511;
            5'd4:    t = 16'd969;
            5'd5:    t = 16'd621;
            5'd6:    t = 16'd398;
            5'd7:    t = 16'd255;
            5'd8:    t = 16'd164;
            5'd9:    t = 16'd105;
            5'd10:   t = 16'd67;
            5'd11:   t = 16'd43;
            5'd12:   t = 16'd28;
            5'd13:   t = 16'd18;
            5'd14:   t = 16'd11;
            5'd15:   t = 16'd7;
            5'd16:   t = 16'd5;
            5'd17:   t = 16'd3;
            5'd18:   t = 16'd2;
            5'd19:   t = 16'd1;
            default: t = 16'd1;
        endcase
        return t;
    endfunction

    function automatic logic [15:0] alpha_h_lut(input logic [4:0] idx);
        logic [15:0] t;
        case (idx)
            5'd0:    t = 16'd84;
            5'd1:    t = 16'd57;
            5'd2:    t = 16'd38;
            5'd3:    t = 16'd25;
            5'd4:    t = 16'd17;
            5'd5:    t = 16'd11;
            5'd6:    t = 16'd8;
            5'd7:    t = 16'd5;
            5'd8:    t = 16'd3;
            5'd9:    t = 16'd2;
            5'd10:   t = 16'd2;
            5'd11:   t = 16'd1;
            5'd12:   t = 16'd1;
            default: t = 16'd0;
        endcase
        return t;
    endfunction

    function automatic logic [15:0] beta_h_lut(input logic [4:0] idx);
        logic [15:0] t;
        case (idx)
            5'd0:    t = 16'd1;
            5'd1:    t = 16'd1;
            5'd2:    t = 16'd3;
            5'd3:    t = 16'd6;
            5'd4:    t = 16'd13;
            5'd5:    t = 16'd28;
            5'd6:    t = 16'd55;
            5'd7:    t = 16'd97;
            5'd8:    t = 16'd147;
            5'd9:    t = 16'd192;
            5'd10:   t = 16'd223;
            5'd11:   t = 16'd240;
            5'd12:   t = 16'd248;
            5'd13:   t = 16'd253;
            5'd14:   t = 16'd254;
            5'd15:   t = 16'd255;
            default: t = 16'd256;
        endcase
        return t;
    endfunction

    // Linear interpolation between adjacent breakpoints; result always lies between t0 and t1.
    function automatic logic [15:0] interp(input logic [15:0] t0, input logic [15:0] t1,
                                           input logic [10:0] f);
        logic signed [17:0] diff;
        logic signed [29:0] prod;
        diff = $signed({2'b00, t1}) - $signed({2'b00, t0});
        prod = $signed({{12{diff[17]}}, diff}) * $signed({19'd0, f});
        return 16'($signed({14'd0, t0}) + (prod >>> 11));
    endfunction

    // One Euler step of dg/dt = a*(1-g) - b*g, wide enough that only the final clamp limits g.
    function automatic logic [15:0] euler(input logic [15:0] g, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] dte);
        logic signed [39:0] gs;
        logic signed [39:0] as;
        logic signed [39:0] bs;
        logic signed [39:0] d;
        logic signed [55:0] delta;
        logic signed [55:0] gn;
        logic [15:0]        res;
        gs    = $signed({24'd0, g});
        as    = $signed({24'd0, a});
        bs    = $signed({24'd0, b});
        d     = (as * (40'sd32768 - gs) - bs * gs) >>> 8;
        delta = ($signed({40'd0, dte}) * $signed({{16{d[39]}}, d})) >>> 8;
        gn    = $signed({40'd0, g}) + delta;
        if (gn < 56'sd0) begin
            res = 16'd0;
        end else if (gn > 56'sd32767) begin
            res = 16'd32767;
        end else begin
            res = gn[15:0];
        end
        return res;
    endfunction

    logic signed [15:0] v_s;
    logic signed [15:0] v_clamp;
    logic [15:0]        u;
    logic [4:0]         k;
    logic [4:0]         k1;
    logic [10:0]        f;
    logic [15:0]        dte;
    logic [15:0]        am;
    logic [15:0]        bm;
    logic [15:0]        ah;
    logic [15:0]        bh;
    logic [15:0]        m_q;
    logic [15:0]        m_d;
    logic [15:0]        h_q;
    logic [15:0]        h_d;

    always_comb begin
        v_s = $signed(V);
        if (v_s < VMin) begin
            v_clamp = VMin;
        end else if (v_s > VMax) begin
            v_clamp = VMax;
        end else begin
            v_clamp = v_s;
        end
        // Offset fits 16 unsigned bits (0..40959) even though it overflows the signed range.
        u   = v_clamp - VMin;
        k   = u[15:11];
        f   = u[10:0];
        k1  = k + 5'd1;
        dte = dt[15] ? 16'd0 : dt;
    end

    always_comb begin
        am  = interp(alpha_m_lut(k), alpha_m_lut(k1), f);
        bm  = interp(beta_m_lut(k), beta_m_lut(k1), f);
        ah  = interp(alpha_h_lut(k), alpha_h_lut(k1), f);
        bh  = interp(beta_h_lut(k), beta_h_lut(k1), f);
        m_d = euler(m_q, am, bm, dte);
        h_d = euler(h_q, ah, bh, dte);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q <= M_INIT;
            h_q <= H_INIT;
        end else begin
            m_q <= m_d;
            h_q <= h_d;
        end
    end

    assign m_next = m_q;
    assign h_next = h_q;

endmodule

// File: tb/tb_na_gate_update.sv
// Scoreboard bench for na_gate_update: a real-valued reference model of the HH rates feeds an
// expected-value queue; a monitor compares every registered update.
module tb_na_gate_update;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] V;
    logic [15:0] dt;
    logic [15:0] m_next;
    logic [15:0] h_next;

    always #5 clk = ~clk;

    na_gate_update dut (
        .clk    (clk),
        .reset  (reset),
        .V      (V),
        .dt     (dt),
        .m_next (m_next),
        .h_next (h_next)
    );

    localparam longint M0 = 1734;
    localparam longint H0 = 19540;

    longint      am_t[21];
    longint      bm_t[21];
    longint      ah_t[21];
    longint      bh_t[21];
    longint      m_mod;
    longint      h_mod;
    longint      prev_m;
    longint      h_prev;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          checks = 0;
    int          errors = 0;
    bit          mono = 1'b0;
    int          seg_len;
    logic [15:0] vr;
    logic [15:0] dr;

    function automatic longint q88(input real r);
        return longint'($rtoi(r * 256.0 + 0.5));
    endfunction

    task automatic build_tables();
        real v;
        real x;
        for (int i = 0; i < 21; i++) begin
            v = -96.0 + 8.0 * i;
            x = v + 40.0;
            am_t[i] = (i == 7) ? 256 : q88(0.1 * x / (1.0 - $exp(-x / 10.0)));
            bm_t[i] = q88(4.0 * $exp(-(v + 65.0) / 18.0));
            ah_t[i] = q88(0.07 * $exp(-(v + 65.0) / 20.0));
            bh_t[i] = q88(1.0 / (1.0 + $exp(-(v + 35.0) / 10.0)));
        end
    endtask

    function automatic longint lut(input int sel, input int idx);
        case (sel)
            0:       return am_t[idx];
            1:       return bm_t[idx];
            2:       return ah_t[idx];
            default: return bh_t[idx];
        endcase
    endfunction

    function automatic longint rate(input int sel, input longint v);
        longint vc;
        longint u;
        longint t0;
        longint t1;
        vc = (v < -24576) ? -24576 : ((v > 16383) ? 16383 : v);
        u  = vc + 24576;
        t0 = lut(sel, int'(u / 2048));
        t1 = lut(sel, int'(u / 2048) + 1);
        return t0 + (((t1 - t0) * (u % 2048)) >>> 11);
    endfunction

    function automatic longint step(input longint g, input longint a, input longint b,
                                    input longint dtv);
        longint d;
        longint gn;
        d  = (a * (32768 - g) - b * g) >>> 8;
        gn = g + (((dtv < 0) ? 0 : dtv) * d >>> 8);
        if (gn < 0) gn = 0;
        if (gn > 32767) gn = 32767;
        return gn;
    endfunction

    task automatic check_eq(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_bound(input string name, input longint act, input longint lo,
                               input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required [%0d,%0d] (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // One modelled cycle: inputs applied here are sampled at the following rising edge.
    task automatic drive(input logic [15:0] v, input logic [15:0] d);
        longint vs;
        longint ds;
        @(negedge clk);
        V  = v;
        dt = d;
        vs = longint'($signed(v));
        ds = longint'($signed(d));
        m_mod = step(m_mod, rate(0, vs), rate(1, vs), ds);
        h_mod = step(h_mod, rate(2, vs), rate(3, vs), ds);
        exp_q.push_back({m_mod[15:0], h_mod[15:0]});
    endtask

    task automatic run(input logic [15:0] v, input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) drive(v, d);
        @(negedge clk);
        dt = 16'd0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_reset_m", longint'(m_next), M0);
        check_eq("async_reset_h", longint'(h_next), H0);
        exp_q.delete();
        m_mod  = M0;
        h_mod  = H0;
        prev_m = M0;
        h_prev = H0;
        mono   = 1'b0;
        dt     = 16'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("m_next", longint'(m_next), longint'(e[31:16]));
            check_eq("h_next", longint'(h_next), longint'(e[15:0]));
            if (mono) begin
                check_bound("m_monotonic", longint'(m_next), prev_m, 32767);
                check_bound("h_monotonic", longint'(h_next), 0, h_prev);
            end
            prev_m = longint'(m_next);
            h_prev = longint'(h_next);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        V     = 16'd0;
        dt    = 16'd0;
        build_tables();
        m_mod = M0;
        h_mod = H0;

        repeat (4) begin
            @(negedge clk);
            check_eq("reset_hold_m", longint'(m_next), M0);
            check_eq("reset_hold_h", longint'(h_next), H0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("post_release_m", longint'(m_next), M0);
        check_eq("post_release_h", longint'(h_next), H0);

        run(16'd10240, 16'd0, 50);
        check_eq("dt0_hold_m", longint'(m_next), M0);
        check_eq("dt0_hold_h", longint'(h_next), H0);

        run(16'hBF00, 16'd3, 200);
        run(16'hBF00, 16'hFF00, 30);

        do_reset();
        mono = 1'b1;
        run(16'd10240, 16'd13, 400);
        mono = 1'b0;
        check_bound("m_rise_final", longint'(m_next), 30000, 32767);
        check_bound("h_fall_final", longint'(h_next), 0, 1000);

        do_reset();
        run(16'h7FFF, 16'd13, 60);
        do_reset();
        run(16'h3FFF, 16'd13, 60);
        do_reset();
        run(16'h8000, 16'd13, 60);
        do_reset();
        run(16'hA000, 16'd13, 60);

        do_reset();
        run(16'd10240, 16'd2560, 1);
        check_eq("big_dt_m_sat", longint'(m_next), 32767);
        check_eq("big_dt_h_sat", longint'(h_next), 0);
        run(16'd10240, 16'd2560, 20);

        do_reset();
        for (int i = 0; i < 7; i++) drive(16'd10240, 16'd13);
        do_reset();

        for (int s = 0; s < 30; s++) begin
            seg_len = int'($urandom_range(5, 60));
            if ($urandom_range(0, 4) == 0) do_reset();
            for (int i = 0; i < seg_len; i++) begin
                vr = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                 : 16'(int'($urandom_range(0, 40959)) - 24576);
                dr = ($urandom_range(0, 5) == 0) ? 16'($urandom)
                                                 : 16'(int'($urandom_range(0, 700)) - 150);
                drive(vr, dr);
            end
            @(negedge clk);
            dt = 16'd0;
        end

        @(negedge clk);
        check_eq("queue_drained", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
